// File: rtl/obi_master_pipe_if.sv
// OBI A/R channel bundle between the pipelined manager and a crossbar port.
// The master modport is the manager side; the slave modport is the fabric side.
interface obi_master_pipe_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    req;
  logic                    gnt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    err;

  modport master (
    output req, addr, we, be, wdata, rready,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata, rready,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/obi_master_pipe.sv
// Pipelined OBI manager: one A-phase holding register, a ring of in-flight
// entries retired in issue order, and a buffered valid/ready response port.
module obi_master_pipe #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ERR_CNT_WIDTH   = 8,
  localparam int BE_WIDTH  = DATA_WIDTH / 8,
  localparam int PTR_WIDTH = $clog2(MAX_OUTSTANDING),
  localparam int CNT_WIDTH = PTR_WIDTH + 1
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     req_i,
  output logic                     gnt_o,
  input  logic                     we_i,
  input  logic [ADDR_WIDTH-1:0]    addr_i,
  input  logic [BE_WIDTH-1:0]      be_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [DATA_WIDTH-1:0]    rsp_rdata_o,
  output logic                     rsp_err_o,
  output logic                     rsp_we_o,
  obi_master_pipe_if.master        obi,
  input  logic                     err_clr_i,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
  output logic [CNT_WIDTH-1:0]     inflight_o,
  output logic                     idle_o
);

  logic                     active_q;
  logic                     a_valid_q;
  logic                     a_we_q;
  logic [ADDR_WIDTH-1:0]    a_addr_q;
  logic [BE_WIDTH-1:0]      a_be_q;
  logic [DATA_WIDTH-1:0]    a_wdata_q;
  logic [PTR_WIDTH-1:0]     aptr_q, rptr_q, cptr_q;
  logic [CNT_WIDTH-1:0]     inflight_q;
  logic [CNT_WIDTH-1:0]     rwait_q;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

  logic [MAX_OUTSTANDING-1:0] ent_we, ent_done, ent_err;
  logic [DATA_WIDTH-1:0]      ent_rdata [MAX_OUTSTANDING];

  logic               a_fire, r_fire, pop, accept;
  logic [CNT_WIDTH:0] used;

  assign a_fire = a_valid_q & obi.gnt;
  // rwait_q counts entries issued but not yet answered; a response with none
  // pending is a protocol violation and must not disturb any state.
  assign r_fire = obi.rvalid & obi.rready & (rwait_q != '0);
  assign pop    = ent_done[cptr_q] & rsp_ready_i;
  assign used   = {1'b0, inflight_q} + (CNT_WIDTH + 1)'(a_valid_q);
  assign gnt_o  = active_q & (~a_valid_q | a_fire)
                & (used < (CNT_WIDTH + 1)'(MAX_OUTSTANDING));
  assign accept = req_i & gnt_o;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      active_q  <= 1'b0;
      a_valid_q <= 1'b0;
      a_we_q    <= 1'b0;
      a_addr_q  <= '0;
      a_be_q    <= '0;
      a_wdata_q <= '0;
    end else begin
      active_q <= 1'b1;
      if (accept) begin
        a_valid_q <= 1'b1;
        a_we_q    <= we_i;
        a_addr_q  <= addr_i;
        a_be_q    <= be_i;
        a_wdata_q <= wdata_i;
      end else if (a_fire) begin
        a_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      aptr_q     <= '0;
      rptr_q     <= '0;
      cptr_q     <= '0;
      inflight_q <= '0;
      rwait_q    <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (a_fire) aptr_q <= aptr_q + 1'b1;
      if (r_fire) rptr_q <= rptr_q + 1'b1;
      if (pop)    cptr_q <= cptr_q + 1'b1;
      inflight_q <= inflight_q + CNT_WIDTH'(a_fire) - CNT_WIDTH'(pop);
      rwait_q    <= rwait_q + CNT_WIDTH'(a_fire) - CNT_WIDTH'(r_fire);
      if (err_clr_i) begin
        err_cnt_q <= '0;
      end else if (r_fire && obi.err && !(&err_cnt_q)) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_entry
      logic                  we_q, done_q, err_q;
      logic [DATA_WIDTH-1:0] rdata_q;

      always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
          we_q    <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= '0;
        end else begin
          if (a_fire && aptr_q == PTR_WIDTH'(gi)) begin
            we_q   <= a_we_q;
            done_q <= 1'b0;
          end
          if (r_fire && rptr_q == PTR_WIDTH'(gi)) begin
            rdata_q <= obi.rdata;
            err_q   <= obi.err;
            done_q  <= 1'b1;
          end
          // Clearing done on pop keeps an empty ring from showing a stale response.
          if (pop && cptr_q == PTR_WIDTH'(gi)) begin
            done_q <= 1'b0;
          end
        end
      end

      assign ent_we[gi]    = we_q;
      assign ent_done[gi]  = done_q;
      assign ent_err[gi]   = err_q;
      assign ent_rdata[gi] = rdata_q;
    end
  endgenerate

  assign obi.req    = a_valid_q;
  assign obi.we     = a_we_q;
  assign obi.addr   = a_addr_q;
  assign obi.be     = a_be_q;
  assign obi.wdata  = a_wdata_q;
  assign obi.rready = active_q;

  assign rsp_valid_o = ent_done[cptr_q];
  assign rsp_rdata_o = ent_rdata[cptr_q];
  assign rsp_err_o   = ent_err[cptr_q];
  assign rsp_we_o    = ent_we[cptr_q];

  assign err_cnt_o  = err_cnt_q;
  assign inflight_o = inflight_q;
  assign idle_o     = ~a_valid_q & (inflight_q == '0);

endmodule

// File: tb/tb_obi_master_pipe.sv
// Directed bench for obi_master_pipe: single read/write, fill, ordering with
// wrap, error saturation/clear, and reset with transactions in flight.
module tb_obi_master_pipe;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int EW = 2;

  logic          clk_i = 1'b0;
  logic          reset_ni = 1'b0;
  logic          req_i = 1'b0;
  logic          gnt_o;
  logic          we_i = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic [3:0]    be_i = '0;
  logic [DW-1:0] wdata_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_err_o;
  logic          rsp_we_o;
  logic          err_clr_i = 1'b0;
  logic [EW-1:0] err_cnt_o;
  logic [2:0]    inflight_o;
  logic          idle_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  obi_master_pipe_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) obi ();

  obi_master_pipe #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO), .ERR_CNT_WIDTH(EW)
  ) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i), .addr_i(addr_i),
    .be_i(be_i), .wdata_i(wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .rsp_we_o(rsp_we_o),
    .obi(obi),
    .err_clr_i(err_clr_i), .err_cnt_o(err_cnt_o),
    .inflight_o(inflight_o), .idle_o(idle_o)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // One complete transaction: accept, wait_n wait cycles before grant,
  // rvalid the cycle after grant, then pop the response.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, input int wait_n,
                        input logic [31:0] rdata, input logic err, input logic clr,
                        output int req_cycles, output logic hold_ok, output logic rv,
                        output logic [31:0] r_rdata, output logic r_err, output logic r_we);
    req_cycles = 0;
    hold_ok = 1'b1;
    req_i = 1'b1; we_i = we; addr_i = addr; be_i = be; wdata_i = wdata;
    #2;
    check_val("accept_gnt", gnt_o, 1);
    cyc();
    req_i = 1'b0; we_i = ~we; addr_i = ~addr; be_i = ~be; wdata_i = ~wdata;
    for (int k = 0; k <= wait_n; k++) begin
      obi.gnt = (k == wait_n);
      #2;
      if (obi.req) req_cycles++;
      if (obi.addr !== addr || obi.we !== we || obi.be !== be || obi.wdata !== wdata)
        hold_ok = 1'b0;
      cyc();
    end
    obi.gnt = 1'b0;
    obi.rvalid = 1'b1; obi.rdata = rdata; obi.err = err; err_clr_i = clr;
    #2;
    if (obi.req) req_cycles++;
    cyc();
    obi.rvalid = 1'b0; obi.rdata = '0; obi.err = 1'b0; err_clr_i = 1'b0;
    rsp_ready_i = 1'b1;
    #2;
    rv = rsp_valid_o; r_rdata = rsp_rdata_o; r_err = rsp_err_o; r_we = rsp_we_o;
    cyc();
    rsp_ready_i = 1'b0;
    $display("txn we=%0d addr=0x%08h be=%b rsp_valid=%0d rdata=0x%08h err=%0d rsp_we=%0d",
             we, addr, be, rv, r_rdata, r_err, r_we);
  endtask

  int          req_cycles;
  logic        hold_ok, rv, r_err, r_we;
  logic [31:0] r_rdata;
  int          acc;
  int          issued, granted, rsent, popped, last_due, max_inflight;
  int          due_q[$];
  logic [9:0]  we_pat;

  initial begin
    obi.gnt = 1'b0; obi.rvalid = 1'b0; obi.rdata = '0; obi.err = 1'b0;

    // Reset values
    repeat (2) cyc();
    #2;
    check_val("rst_gnt", gnt_o, 0);
    check_val("rst_obi_req", obi.req, 0);
    check_val("rst_rready", obi.rready, 0);
    check_val("rst_rsp_valid", rsp_valid_o, 0);
    check_val("rst_inflight", inflight_o, 0);
    check_val("rst_idle", idle_o, 1);
    check_val("rst_err_cnt", err_cnt_o, 0);
    reset_ni = 1'b1;
    cyc();

    // Single read, two wait cycles before grant
    do_txn(1'b0, 32'h0000_0040, 4'hF, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 1'b0,
           req_cycles, hold_ok, rv, r_rdata, r_err, r_we);
    #2;
    check_val("rd_req_cycles", req_cycles, 3);
    check_val("rd_hold", hold_ok, 1);
    check_val("rd_rsp_valid", rv, 1);
    check_val("rd_rdata", r_rdata, 32'hDEAD_BEEF);
    check_val("rd_we", r_we, 0);
    check_val("rd_err", r_err, 0);
    check_val("rd_idle", idle_o, 1);
    check_val("rd_rsp_valid_after", rsp_valid_o, 0);

    // Single write with partial byte enables
    do_txn(1'b1, 32'h0000_0080, 4'b0011, 32'h1234_5678, 1, 32'h0, 1'b0, 1'b0,
           req_cycles, hold_ok, rv, r_rdata, r_err, r_we);
    #2;
    check_val("wr_req_cycles", req_cycles, 2);
    check_val("wr_hold", hold_ok, 1);
    check_val("wr_rsp_valid", rv, 1);
    check_val("wr_rsp_we", r_we, 1);
    check_val("wr_idle", idle_o, 1);

    // Fill: grant always, no responses, no pops
    obi.gnt = 1'b1; req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; acc = 0;
    for (int c = 0; c < 8; c++) begin
      addr_i = 32'h200 + 32'(c * 4);
      #2;
      if (req_i && gnt_o) acc++;
      cyc();
    end
    req_i = 1'b0; obi.gnt = 1'b0;
    #2;
    check_val("fill_accepts", acc, 4);
    check_val("fill_gnt_low", gnt_o, 0);
    check_val("fill_inflight", inflight_o, 4);
    cyc();
    for (int i = 0; i < 4; i++) begin
      obi.rvalid = 1'b1; obi.rdata = 32'h100 + 32'(i);
      cyc();
    end
    obi.rvalid = 1'b0;
    #2;
    check_val("full_rsp_valid", rsp_valid_o, 1);
    check_val("full_gnt_still_low", gnt_o, 0);
    check_val("full_pop0_rdata", rsp_rdata_o, 32'h100);
    rsp_ready_i = 1'b1;
    cyc();
    rsp_ready_i = 1'b0;
    #2;
    check_val("reopen_gnt", gnt_o, 1);
    check_val("reopen_inflight", inflight_o, 3);
    rsp_ready_i = 1'b1;
    for (int i = 1; i < 4; i++) begin
      #2;
      check_val("fill_drain_rdata", rsp_rdata_o, 32'h100 + 32'(i));
      $display("txn fill pop %0d rdata=0x%08h", i, rsp_rdata_o);
      cyc();
    end
    rsp_ready_i = 1'b0;
    #2;
    check_val("fill_idle", idle_o, 1);

    // Ordering and wrap: 10 mixed transactions, random grant/rvalid/ready timing
    we_pat = 10'b10_1100_1010;
    issued = 0; granted = 0; rsent = 0; popped = 0; last_due = -1; max_inflight = 0;
    for (int n = 0; n < 400 && popped < 10; n++) begin
      req_i   = (issued < 10);
      addr_i  = 32'h1000 + 32'(issued * 4);
      we_i    = we_pat[issued % 10];
      wdata_i = 32'h5A00_0000 + 32'(issued);
      be_i    = 4'hF;
      obi.gnt = ($urandom_range(0, 3) != 0);
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      if (due_q.size() > 0 && due_q[0] <= n) begin
        obi.rvalid = 1'b1;
        obi.rdata  = 32'hC0DE_0000 + 32'(rsent);
      end else begin
        obi.rvalid = 1'b0;
      end
      #2;
      if (int'(inflight_o) > max_inflight) max_inflight = int'(inflight_o);
      if (req_i && gnt_o) issued++;
      if (obi.req && obi.gnt) begin
        granted++;
        last_due = n + 1 + int'($urandom_range(0, 3));
        if (due_q.size() > 0 && last_due <= due_q[$]) last_due = due_q[$] + 1;
        due_q.push_back(last_due);
      end
      if (obi.rvalid) begin
        void'(due_q.pop_front());
        rsent++;
      end
      if (rsp_valid_o && rsp_ready_i) begin
        check_val("order_rdata", rsp_rdata_o, 32'hC0DE_0000 + 32'(popped));
        check_val("order_we", rsp_we_o, we_pat[popped]);
        $display("txn order pop %0d rdata=0x%08h we=%0d", popped, rsp_rdata_o, rsp_we_o);
        popped++;
      end
      cyc();
    end
    req_i = 1'b0; obi.gnt = 1'b0; obi.rvalid = 1'b0; rsp_ready_i = 1'b0;
    #2;
    check_val("order_count", popped, 10);
    check_val("order_granted", granted, 10);
    check_val("order_max_inflight_ok", (max_inflight <= MO), 1);
    check_val("order_idle", idle_o, 1);
    cyc();

    // Error counter saturation, then clear winning over an increment
    for (int k = 1; k <= 6; k++) begin
      do_txn(1'b0, 32'h300 + 32'(k * 4), 4'hF, 32'h0, 0, 32'(k), 1'b1, 1'b0,
             req_cycles, hold_ok, rv, r_rdata, r_err, r_we);
      check_val("err_rsp_err", r_err, 1);
      check_val("err_cnt_sat", err_cnt_o, (k < 3) ? k : 3);
    end
    do_txn(1'b0, 32'h400, 4'hF, 32'h0, 0, 32'h0, 1'b1, 1'b1,
           req_cycles, hold_ok, rv, r_rdata, r_err, r_we);
    check_val("err_clr_wins", err_cnt_o, 0);
    do_txn(1'b1, 32'h404, 4'hF, 32'h0, 0, 32'h0, 1'b1, 1'b0,
           req_cycles, hold_ok, rv, r_rdata, r_err, r_we);
    check_val("err_after_clr", err_cnt_o, 1);

    // Reset with three transactions in flight
    obi.gnt = 1'b1; req_i = 1'b1; we_i = 1'b1; be_i = 4'hF;
    for (int c = 0; c < 3; c++) begin
      addr_i = 32'h500 + 32'(c * 4);
      cyc();
    end
    req_i = 1'b0;
    cyc();
    #2;
    check_val("pre_rst_inflight", inflight_o, 3);
    check_val("pre_rst_idle", idle_o, 0);
    reset_ni = 1'b0; obi.gnt = 1'b0;
    #2;
    check_val("mid_rst_gnt", gnt_o, 0);
    check_val("mid_rst_obi_req", obi.req, 0);
    check_val("mid_rst_obi_we", obi.we, 0);
    check_val("mid_rst_obi_addr", obi.addr, 0);
    check_val("mid_rst_rready", obi.rready, 0);
    check_val("mid_rst_inflight", inflight_o, 0);
    check_val("mid_rst_idle", idle_o, 1);
    check_val("mid_rst_err_cnt", err_cnt_o, 0);
    cyc();
    cyc();
    reset_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      obi.rvalid = 1'b1; obi.rdata = 32'hBAD0_0000 + 32'(i); obi.err = 1'b1;
      #2;
      check_val("stray_rsp_valid", rsp_valid_o, 0);
      cyc();
    end
    obi.rvalid = 1'b0; obi.err = 1'b0;
    #2;
    check_val("stray_rsp_valid_end", rsp_valid_o, 0);
    check_val("stray_err_cnt", err_cnt_o, 0);
    check_val("stray_inflight", inflight_o, 0);
    check_val("stray_idle", idle_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/obi_master_pipe.md
# obi_master_pipe

Pipelined OBI manager that replaces the single-transaction OBI master. It accepts controller requests through a valid/grant handshake and issues them on the OBI A channel with full byte-enable control. It keeps up to MAX_OUTSTANDING transactions in flight and returns in-order responses (rdata, err, we) through a buffered valid/ready response port. It sits between a local controller (DMA engine or test sequencer) and an OBI crossbar port.

## Interface
- ADDR_WIDTH, 32, address width; 32 or 64.
- DATA_WIDTH, 32, data width; 32 or 64; byte-enable width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 4, maximum granted-but-undelivered transactions; power of two, 2..16.
- ERR_CNT_WIDTH, 8, width of the saturating error counter.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk_i  in  1  clock.
- reset_ni  in  1  async active-low reset.
- req_i  in  1  controller request valid.
- gnt_o  out  1  controller request accepted this cycle (req_i & gnt_o = accept).
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  ADDR_WIDTH  request address.
- be_i  in  DATA_WIDTH/8  byte enables.
- wdata_i  in  DATA_WIDTH  write data.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  controller consumes response.
- rsp_rdata_o  out  DATA_WIDTH  captured obi_rdata_i.
- rsp_err_o  out  1  captured obi_err_i.
- rsp_we_o  out  1  we of the transaction this response belongs to.
- obi_req_o / obi_gnt_i  out/in  1  OBI A-channel handshake.
- obi_addr_o  out  ADDR_WIDTH; obi_we_o out 1; obi_be_o out DATA_WIDTH/8; obi_wdata_o out DATA_WIDTH: A-phase payload.
- obi_rvalid_i  in  1; obi_rready_o out 1; obi_rdata_i in DATA_WIDTH; obi_err_i in 1: R channel.
- err_clr_i  in  1  synchronous clear of error counter.
- err_cnt_o  out  ERR_CNT_WIDTH  count of R handshakes with err=1, saturating.
- inflight_o  out  $clog2(MAX_OUTSTANDING)+1  current in-flight count.
- idle_o  out  1  no A-phase pending and inflight == 0.

## Operation
- A-phase register holds one pending request (a_valid). a_fire = obi_req_o & obi_gnt_i; obi_req_o = a_valid.
- gnt_o = (!a_valid | a_fire) & (inflight_q + a_valid < MAX_OUTSTANDING). It is independent of req_i and of R-channel inputs (no comb path from rvalid/rsp_ready).
- On accept: the A register loads addr_i, we_i, be_i, wdata_i and sets a_valid. Otherwise it clears a_valid on a_fire.
- While a_valid=1, all obi_* A-phase outputs are stable until grant; the request is never retracted.
- Tracking ring of MAX_OUTSTANDING entries {we, done, rdata, err} with three pointers:
  - aptr: on a_fire, write we and clear done.
  - rptr: on R handshake (obi_rvalid_i & obi_rready_o), write rdata/err and set done.
  - cptr: on rsp_valid_o & rsp_ready_i, pop the entry.
- All pointers wrap modulo MAX_OUTSTANDING.
- inflight_q: +1 on a_fire, -1 on controller pop; both in the same cycle means unchanged. It never exceeds MAX_OUTSTANDING.
- rsp_valid_o = done[cptr]. rsp_* outputs come from entry cptr. rsp_rdata_o passes stored data through even for writes.
- obi_rready_o = 1 whenever not in reset. Overflow is impossible by the credit rule.
- R handshake with no in-flight entry (protocol violation) is ignored; the counter is unaffected.
- Error counter: +1 per R handshake with obi_err_i=1, saturating at all-ones. err_clr_i forces 0 and wins over a simultaneous increment.
- Reset mid-operation: all in-flight state is discarded and pointers are zeroed. Responses arriving after reset deassertion with inflight 0 are ignored.

## Timing
- Reset values: gnt_o 0 during reset; obi_req_o 0, obi_we_o 0, obi_addr_o/obi_be_o/obi_wdata_o 0, obi_rready_o 0, rsp_valid_o 0, rsp_* 0, err_cnt_o 0, inflight_o 0, idle_o 1.
- Accept in cycle N gives obi_req_o=1 from N+1.
- With grant at N+1 and rvalid at N+2 (earliest legal), rsp_valid_o=1 at N+3.
- Back-to-back: with obi_gnt_i=1 and rsp_ready_i=1, the block sustains one accept per cycle. inflight plateaus at the gnt-to-pop latency and stalls once it reaches MAX_OUTSTANDING.
- Full: when inflight + a_valid == MAX_OUTSTANDING, gnt_o=0. It reopens the cycle after a controller pop.

## Test plan
- Single read: accept addr 0x0000_0040; grant after 2 wait cycles; rvalid with rdata 0xDEAD_BEEF -> obi_req_o high exactly 3 cycles with stable addr; rsp_valid_o with rdata 0xDEAD_BEEF, we=0, err=0; idle_o returns to 1.
- Single write with be_i=4'b0011, wdata 0x1234_5678 -> obi_we_o=1, obi_be_o=0011 held until grant; one response with rsp_we_o=1.
- Fill: MAX_OUTSTANDING=4, gnt always 1, rvalid held 0, rsp_ready 0 -> exactly 4 accepts, then gnt_o=0 and inflight_o=4. One pop after responses arrive -> gnt_o=1 next cycle.
- Ordering/wrap: 10 mixed reads/writes with random rvalid delays -> responses delivered in issue order, rsp_we_o matches each issue, pointers wrap twice without loss.
- Errors: ERR_CNT_WIDTH=2, six err=1 responses -> err_cnt_o saturates at 3. err_clr_i together with an error -> err_cnt_o=0.
- Reset with 3 in flight -> all outputs at reset values; post-reset stray rvalid ignored, rsp_valid_o stays 0.
